// File: rtl/status_branch_unit.sv
// Status-flag register plus a conditional branch resolver. A branch request is
// captured in IDLE, evaluated against the latched flags in EVAL, and reported in DONE.
module status_branch_unit #(
  parameter int PC_W  = 9,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_s,
  input  logic [2:0]       z_in,
  output logic [2:0]       status_out,
  input  logic             br_req,
  input  logic [2:0]       br_cond,
  input  logic [IMM_W-1:0] br_imm,
  input  logic [PC_W-1:0]  pc_in,
  output logic             br_busy,
  output logic             br_done,
  output logic             br_taken,
  output logic             br_err,
  output logic [PC_W-1:0]  pc_next
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1'b1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       status_q;
  logic [2:0]       cond_q, cond_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             taken_q, taken_d;
  logic             err_q, err_d;
  logic [PC_W-1:0]  pcn_q, pcn_d;
  logic             busy_q, done_q;
  logic [1:0]       res_s;
  logic [PC_W-1:0]  pc_plus1_s;

  // Returns {illegal, taken}; flags are {V, N, Zf}.
  function automatic logic [1:0] cond_eval(input logic [2:0] cond, input logic [2:0] st);
    logic [1:0] r;
    case (cond)
      3'b000:  r = 2'b01;
      3'b001:  r = {1'b0, st[0]};
      3'b010:  r = {1'b0, ~st[0]};
      3'b011:  r = {1'b0, st[1] ^ st[2]};
      3'b100:  r = {1'b0, (st[1] ^ st[2]) | st[0]};
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  function automatic logic [PC_W-1:0] sext(input logic [IMM_W-1:0] v);
    return PC_W'($signed(v));
  endfunction

  assign res_s      = cond_eval(cond_q, status_q);
  assign pc_plus1_s = pc_q + PC_ONE;

  // Next-state and result computation for the branch FSM.
  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    taken_d = taken_q;
    err_d   = err_q;
    pcn_d   = pcn_q;
    case (state_q)
      S_IDLE: begin
        if (br_req) begin
          cond_d  = br_cond;
          imm_d   = br_imm;
          pc_d    = pc_in;
          state_d = S_EVAL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EVAL: begin
        // A flag load at this edge would race the evaluation, so wait a cycle.
        if (load_s) begin
          state_d = S_EVAL;
        end else begin
          taken_d = res_s[0];
          err_d   = res_s[1];
          pcn_d   = res_s[0] ? (pc_plus1_s + sext(imm_q)) : pc_plus1_s;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= 3'b000;
    end else if (load_s) begin
      status_q <= z_in;
    end else begin
      status_q <= status_q;
    end
  end

  // FSM state, captured operands and registered results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cond_q  <= 3'b000;
      imm_q   <= {IMM_W{1'b0}};
      pc_q    <= {PC_W{1'b0}};
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      pcn_q   <= {PC_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      err_q   <= err_d;
      pcn_q   <= pcn_d;
      busy_q  <= (state_d == S_EVAL);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign status_out = status_q;
  assign br_busy    = busy_q;
  assign br_done    = done_q;
  assign br_taken   = taken_q;
  assign br_err     = err_q;
  assign pc_next    = pcn_q;

endmodule
